controle_estabelecidos: RTL

CONTROLE_ESTABELECIDOS -- requirements
Module: controle_estabelecidos

---
 rtl/controle_estabelecidos.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/controle_estabelecidos.sv
// controle_estabelecidos: two-requester round-robin memory write arbiter with a
// full-memory clear sweep (IDLE -> CLEAR -> DONE).
// Optional feature macro: ESTABELECIDOS_CONTADOR_EN adds count_out, a running
// count of non-zero memory entries, and mirrors the write port onto the read port.
module controle_estabelecidos #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start_in,
    input  logic                  req0_in,
    input  logic                  req1_in,
    input  logic [ADDR_WIDTH-1:0] addr0_in,
    input  logic [ADDR_WIDTH-1:0] addr1_in,
    input  logic [DATA_WIDTH-1:0] data0_in,
    input  logic [DATA_WIDTH-1:0] data1_in,
    output logic                  ack0_out,
    output logic                  ack1_out,
    output logic                  mem_write_en_out,
    output logic [ADDR_WIDTH-1:0] mem_write_addr_out,
    output logic [DATA_WIDTH-1:0] mem_write_data_out,
    output logic                  mem_read_en_out,
    output logic [ADDR_WIDTH-1:0] mem_read_addr_out,
    input  logic [DATA_WIDTH-1:0] mem_read_data_in,
    output logic                  busy_out,
    output logic                  clear_done_out
`ifdef ESTABELECIDOS_CONTADOR_EN
    ,
    output logic [ADDR_WIDTH:0]   count_out
`endif
);

    localparam int unsigned MEM_SIZE = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  last_q, last_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic elig0_c, elig1_c, grant0_c, grant1_c;

    // Round-robin pick: a requester whose ack is showing this cycle sits out.
    assign elig0_c  = req0_in & ~ack0_q;
    assign elig1_c  = req1_in & ~ack1_q;
    assign grant0_c = elig0_c & (~elig1_c | last_q);
    assign grant1_c = elig1_c & (~elig0_c | ~last_q);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sweep_q <= '0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next state and next registered outputs; write address/data hold when idle.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start_in) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = '0;
                    busy_d  = 1'b1;
                end else if (grant0_c) begin
                    ack0_d  = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = addr0_in;
                    wdata_d = data0_in;
                    last_d  = 1'b0;
                end else if (grant1_c) begin
                    ack1_d  = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = addr1_in;
                    wdata_d = data1_in;
                    last_d  = 1'b1;
                end
            end
            CLEAR: begin
                busy_d = 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    sweep_d = sweep_q + ADDR_WIDTH'(1);
                    we_d    = 1'b1;
                    waddr_d = sweep_q + ADDR_WIDTH'(1);
                    wdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack0_out           = ack0_q;
    assign ack1_out           = ack1_q;
    assign mem_write_en_out   = we_q;
    assign mem_write_addr_out = waddr_q;
    assign mem_write_data_out = wdata_q;
    assign busy_out           = busy_q;
    assign clear_done_out     = done_q;

`ifdef ESTABELECIDOS_CONTADOR_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Track non-zero entries from old (read port) vs new data of each requester write.
    always_comb begin
        count_d = count_q;
        if (state_q == CLEAR && state_d == DONE) begin
            count_d = '0;
        end else if (ack0_q | ack1_q) begin
            if (!(|mem_read_data_in) && (|wdata_q)) begin
                count_d = count_q + CNT_W'(1);
            end else if ((|mem_read_data_in) && !(|wdata_q)) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Entry counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out         = count_q;
    assign mem_read_en_out   = we_q;
    assign mem_read_addr_out = waddr_q;
`else
    logic unused_rdata;
    assign unused_rdata      = ^mem_read_data_in;
    assign mem_read_en_out   = 1'b0;
    assign mem_read_addr_out = '0;
`endif

endmodule
